controller_nios2_gen2_0_cpu_debug_mem_master: RTL and testbench
===============================================================

// Module: controller_nios2_gen2_0_cpu_debug_mem_master
// PURPOSE
//  Consumer of the debug-slave sysclk outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
//  Turns host JTAG memory commands into single-word Avalon-MM master reads/writes to system memory (SDRAM).
//  Returns read data on MonDReg and status on monitor_ready/monitor_error, which feed the debug slave.
//  Address auto-increments after every completed access, so the host can stream memory without reloading the address.
// PARAMETERS
//  ADDR_W      24    word-address width; avm_address is the byte address {addr,2'b00}, ADDR_W+2 bits
//  TIMEOUT     255   max cycles avm_waitrequest may stay high before the access aborts with error; range 1..65535
// PORTS
//  clk                      in   1        system clock; same domain as the debug slave sysclk stage
//  reset                    in   1        asynchronous, active-high reset
//  jdo                      in   38       JTAG data word, valid while any take_* strobe is high
//  take_action_ocimem_a     in   1        1-cycle pulse: load address; optional read
//  take_no_action_ocimem_a  in   1        1-cycle pulse: read at current address
//  take_action_ocimem_b     in   1        1-cycle pulse: write jdo data at current address
//  MonDReg                  out  32       last read data, or last write data
//  monitor_ready            out  1        1 = idle and last access complete
//  monitor_error            out  1        sticky error flag (bus timeout or command while busy)
//  avm_address              out  ADDR_W+2 byte address
//  avm_read                 out  1        Avalon read request
//  avm_write                out  1        Avalon write request
//  avm_writedata            out  32      write data (= MonDReg)
//  avm_byteenable           out  4        constant 4'hF
//  avm_readdata             in   32       read data, valid when avm_read && !avm_waitrequest
//  avm_waitrequest          in   1        Avalon stall
// BEHAVIOUR
//  Reset: state IDLE; addr=0; MonDReg=0; monitor_ready=1; monitor_error=0; avm_read=avm_write=0.
//  jdo fields: ADDR = jdo[ADDR_W+1:2]; RD_GO = jdo[34]; WDATA = jdo[34:3].
//  Commands are accepted only in IDLE. Strobe priority when several pulse together: ocimem_a > ocimem_b > no_action_a.
//  ocimem_a: addr<=ADDR; monitor_error<=0. If RD_GO, go to READ; otherwise stay in IDLE.
//  no_action_a: go to READ. ocimem_b: MonDReg<=WDATA, then go to WRITE.
//  FSM: IDLE -> READ|WRITE -> IDLE.
//   - avm_read/avm_write are registered and high for the whole READ/WRITE state.
//   - avm_address and avm_writedata hold stable while avm_waitrequest=1.
//   - Completion cycle (waitrequest=0 in READ/WRITE):
//     READ: MonDReg<=avm_readdata. Both: addr<=addr+1 with wrap from 2^ADDR_W-1 to 0; next state IDLE.
//  monitor_ready falls in the cycle after acceptance and rises in the cycle after completion.
//  Latency, zero-wait slave: strobe at cycle t -> avm_read high t+1 -> MonDReg and ready updated at t+2.
//  Timeout counter: cleared on entry to READ/WRITE; increments each cycle with waitrequest=1.
//   On reaching TIMEOUT: drop request, monitor_error<=1, go to IDLE. addr and MonDReg unchanged.
//  Any strobe outside IDLE: ignored; monitor_error<=1. An in-flight access is never disturbed.
//  Reset asserted mid-access drops avm_read/avm_write immediately (async); all registers return to reset values.
// STRUCTURE
//  Package controller_nios2_gen2_0_cpu_debug_pkg holds:
//   - state encoding (IDLE/READ/WRITE);
//   - jdo field offsets (JDO_RD_GO=34, JDO_WDATA_LSB=3, JDO_ADDR_LSB=2);
//   - BYTEEN_ALL=4'hF.
//  One sub-module: controller_nios2_gen2_0_cpu_debug_mem_timer. It is the TIMEOUT counter, with clear/enable inputs and an expired output.
// TESTING
//  1 Write then read, zero-wait slave:
//    a) ocimem_a ADDR=0x10, RD_GO=0.
//    b) ocimem_b WDATA=0xDEADBEEF -> avm_write to byte 0x40; addr becomes 0x11.
//    c) ocimem_a ADDR=0x10, RD_GO=1 -> avm_read to 0x40; MonDReg=0xDEADBEEF 2 cycles after the strobe.
//  2 Streaming: 4 no_action_a reads from 0x20, slave returning addr as data
//    -> avm_address 0x80,0x84,0x88,0x8C; MonDReg ends at 0x23.
//  3 Waitrequest held 5 cycles (TIMEOUT=255) -> request stable for 6 cycles; completes; monitor_error=0.
//  4 Waitrequest stuck (TIMEOUT=8) -> request dropped after 8 stall cycles; monitor_error=1; addr unchanged.
//    Next ocimem_a clears the error.
//  5 Strobe during busy read, plus ocimem_a and ocimem_b in the same cycle
//    -> busy strobe ignored and sets error; for the same-cycle pair only the address load takes effect.
//  6 ADDR=2^ADDR_W-1 then read -> addr wraps to 0. Assert reset with avm_read high -> avm_read=0 at once; ready=1.

Source files
------------

// File: rtl/controller_nios2_gen2_0_cpu_debug_pkg.sv
// Shared encodings for the JTAG debug memory master: FSM states, jdo field
// offsets and fixed bus constants.
package controller_nios2_gen2_0_cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int JDO_W         = 38;
    localparam int JDO_RD_GO     = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_ADDR_LSB  = 2;
    localparam int DATA_W        = 32;
    localparam int TMR_W         = 16;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/controller_nios2_gen2_0_cpu_debug_mem_timer.sv
// Bus-stall watchdog: down-counter reloaded by clr_i, decremented by en_i;
// expired_o flags the TIMEOUT-th consecutive stall cycle.
module controller_nios2_gen2_0_cpu_debug_mem_timer
    import controller_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TMR_W-1:0] LOAD = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/controller_nios2_gen2_0_cpu_debug_mem_master.sv
// Turns JTAG debug-slave memory commands into single-word Avalon-MM reads and
// writes, with auto-incrementing address and a sticky error flag.
module controller_nios2_gen2_0_cpu_debug_mem_master
    import controller_nios2_gen2_0_cpu_debug_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error,
    output logic [ADDR_W+1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dreg_q, dreg_d;
    logic                ready_q, ready_d;
    logic                error_q, error_d;

    logic [ADDR_W-1:0]   jdo_addr;
    logic [DATA_W-1:0]   jdo_wdata;
    logic                jdo_rd_go;
    logic                any_strobe;
    logic                busy;
    logic                tmr_expired;
    logic                unused_jdo;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
    assign jdo_rd_go  = jdo[JDO_RD_GO];
    assign unused_jdo = ^{jdo[JDO_ADDR_LSB-1:0], jdo[JDO_W-1:JDO_RD_GO+1]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign busy       = (state_q != ST_IDLE);

    // Counter reloads whenever idle, so every access starts with a full budget.
    controller_nios2_gen2_0_cpu_debug_mem_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clr_i     (!busy),
        .en_i      (busy && avm_waitrequest),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            dreg_q  <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dreg_q  <= dreg_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dreg_d  = dreg_q;
        ready_d = ready_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d  = jdo_addr;
                    error_d = 1'b0;
                    if (jdo_rd_go) begin
                        state_d = ST_READ;
                        ready_d = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    dreg_d  = jdo_wdata;
                    state_d = ST_WRITE;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_READ;
                    ready_d = 1'b0;
                end
            end
            ST_READ, ST_WRITE: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    if (state_q == ST_READ) begin
                        dreg_d = avm_readdata;
                    end
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Requests decode straight from the state register so reset drops them at once.
    always_comb begin
        avm_read  = (state_q == ST_READ);
        avm_write = (state_q == ST_WRITE);
    end

    assign avm_address    = {addr_q, 2'b00};
    assign avm_writedata  = dreg_q;
    assign avm_byteenable = BYTEEN_ALL;
    assign MonDReg        = dreg_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;

endmodule

// File: tb/tb_controller_nios2_gen2_0_cpu_debug_mem_master.sv
// Directed bench for the debug memory master with a small one-word Avalon slave.
module tb_controller_nios2_gen2_0_cpu_debug_mem_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0;
    logic        take_na = 1'b0;
    logic        take_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [25:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest = 1'b0;

    logic        rd_echo = 1'b0;
    logic [31:0] slave_mem = '0;
    logic [25:0] wr_addr_seen = '0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    controller_nios2_gen2_0_cpu_debug_mem_master #(
        .ADDR_W  (24),
        .TIMEOUT (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    // Slave: echoes the word address in echo mode, otherwise returns the last written word.
    assign avm_readdata = rd_echo ? {8'h00, avm_address[25:2]} : slave_mem;

    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest) begin
            slave_mem    <= avm_writedata;
            wr_addr_seen <= avm_address;
        end
    end

    function automatic logic [37:0] jdo_addr(input logic [23:0] a, input logic rd_go);
        logic [37:0] j;
        j = '0;
        j[25:2] = a;
        j[34] = rd_go;
        return j;
    endfunction

    function automatic logic [37:0] jdo_wdata(input logic [31:0] w);
        logic [37:0] j;
        j = '0;
        j[34:3] = w;
        return j;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] j);
        take_a = a; take_b = b; take_na = na; jdo = j;
        @(negedge clk);
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0; jdo = '0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({monitor_ready, monitor_error, avm_read, avm_write} !== 4'b1000)
            $display("FAIL reset_flags: got %b want 1000", {monitor_ready, monitor_error, avm_read, avm_write});
        else n_pass++;
        n_total++;
        if (MonDReg !== 32'h0 || avm_address !== 26'h0)
            $display("FAIL reset_regs: MonDReg %h addr %h want 0 0", MonDReg, avm_address);
        else n_pass++;
        n_total++;
        if (avm_byteenable !== 4'hF) $display("FAIL byteenable: got %h want f", avm_byteenable);
        else n_pass++;
    endtask

    task automatic test_write_read();
        rd_echo = 1'b0;
        pulse(1, 0, 0, jdo_addr(24'h10, 1'b0));
        n_total++;
        if (avm_read !== 1'b0 || monitor_ready !== 1'b1 || avm_address !== 26'h40)
            $display("FAIL load_addr: rd %b rdy %b addr %h want 0 1 40", avm_read, monitor_ready, avm_address);
        else n_pass++;
        pulse(0, 1, 0, jdo_wdata(32'hDEADBEEF));
        n_total++;
        if (avm_write !== 1'b1 || avm_address !== 26'h40 || avm_writedata !== 32'hDEADBEEF || monitor_ready !== 1'b0)
            $display("FAIL write_req: wr %b addr %h data %h rdy %b want 1 40 deadbeef 0",
                     avm_write, avm_address, avm_writedata, monitor_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (avm_write !== 1'b0 || monitor_ready !== 1'b1 || avm_address !== 26'h44)
            $display("FAIL write_done: wr %b rdy %b addr %h want 0 1 44", avm_write, monitor_ready, avm_address);
        else n_pass++;
        n_total++;
        if (wr_addr_seen !== 26'h40 || slave_mem !== 32'hDEADBEEF)
            $display("FAIL slave_write: addr %h data %h want 40 deadbeef", wr_addr_seen, slave_mem);
        else n_pass++;
        pulse(1, 0, 0, jdo_addr(24'h10, 1'b1));
        n_total++;
        if (avm_read !== 1'b1 || avm_address !== 26'h40)
            $display("FAIL read_req: rd %b addr %h want 1 40", avm_read, avm_address);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1 || avm_read !== 1'b0)
            $display("FAIL read_data: MonDReg %h rdy %b rd %b want deadbeef 1 0", MonDReg, monitor_ready, avm_read);
        else n_pass++;
    endtask

    task automatic test_streaming();
        rd_echo = 1'b1;
        pulse(1, 0, 0, jdo_addr(24'h20, 1'b0));
        for (int i = 0; i < 4; i++) begin
            pulse(0, 0, 1, '0);
            n_total++;
            if (avm_read !== 1'b1 || avm_address !== 26'(32'h80 + 4 * i))
                $display("FAIL stream_addr[%0d]: rd %b addr %h want 1 %h", i, avm_read, avm_address, 32'h80 + 4 * i);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (MonDReg !== 32'h23) $display("FAIL stream_data: got %h want 23", MonDReg);
        else n_pass++;
    endtask

    // Address 0x24 (next in the stream) stalls for n cycles, then completes.
    task automatic test_wait(input int stalls, input logic [25:0] exp_addr, input logic [31:0] exp_data);
        int stable;
        stable = 0;
        avm_waitrequest = 1'b1;
        pulse(0, 0, 1, '0);
        for (int k = 0; k <= stalls; k++) begin
            if (avm_read === 1'b1 && avm_address === exp_addr) stable++;
            if (k == stalls) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if (stable !== stalls + 1)
            $display("FAIL wait%0d_stable: got %0d want %0d", stalls, stable, stalls + 1);
        else n_pass++;
        n_total++;
        if (avm_read !== 1'b0 || monitor_error !== 1'b0 || monitor_ready !== 1'b1 || MonDReg !== exp_data)
            $display("FAIL wait%0d_done: rd %b err %b rdy %b data %h want 0 0 1 %h",
                     stalls, avm_read, monitor_error, monitor_ready, MonDReg, exp_data);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int held;
        held = 0;
        avm_waitrequest = 1'b1;
        pulse(0, 0, 1, '0);
        for (int k = 0; k < 8; k++) begin
            if (avm_read === 1'b1) held++;
            @(negedge clk);
        end
        n_total++;
        if (held !== 8) $display("FAIL timeout_held: got %0d want 8", held);
        else n_pass++;
        n_total++;
        if (avm_read !== 1'b0 || monitor_error !== 1'b1)
            $display("FAIL timeout_abort: rd %b err %b want 0 1", avm_read, monitor_error);
        else n_pass++;
        n_total++;
        if (avm_address !== 26'h98 || MonDReg !== 32'h25)
            $display("FAIL timeout_keep: addr %h data %h want 98 25", avm_address, MonDReg);
        else n_pass++;
        pulse(1, 0, 0, jdo_addr(24'h30, 1'b0));
        n_total++;
        if (monitor_error !== 1'b0) $display("FAIL error_clear: got %b want 0", monitor_error);
        else n_pass++;
    endtask

    task automatic test_busy_strobe();
        pulse(0, 0, 1, '0);
        pulse(0, 1, 0, jdo_wdata(32'h12345678));
        n_total++;
        if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== 26'hC0 || MonDReg !== 32'h25)
            $display("FAIL busy_undisturbed: rd %b wr %b addr %h data %h want 1 0 c0 25",
                     avm_read, avm_write, avm_address, MonDReg);
        else n_pass++;
        n_total++;
        if (monitor_error !== 1'b1) $display("FAIL busy_error: got %b want 1", monitor_error);
        else n_pass++;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        n_total++;
        if (MonDReg !== 32'h30 || avm_read !== 1'b0 || monitor_error !== 1'b1)
            $display("FAIL busy_complete: data %h rd %b err %b want 30 0 1", MonDReg, avm_read, monitor_error);
        else n_pass++;
    endtask

    task automatic test_priority();
        pulse(1, 1, 0, jdo_addr(24'h50, 1'b0));
        n_total++;
        if (avm_write !== 1'b0 || avm_read !== 1'b0 || avm_address !== 26'h140 || MonDReg !== 32'h30 || monitor_error !== 1'b0)
            $display("FAIL prio_a_over_b: wr %b rd %b addr %h data %h err %b want 0 0 140 30 0",
                     avm_write, avm_read, avm_address, MonDReg, monitor_error);
        else n_pass++;
        pulse(0, 1, 1, jdo_wdata(32'hCAFEF00D));
        n_total++;
        if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_writedata !== 32'hCAFEF00D)
            $display("FAIL prio_b_over_na: wr %b rd %b data %h want 1 0 cafef00d", avm_write, avm_read, avm_writedata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_wrap_and_reset();
        rd_echo = 1'b1;
        pulse(1, 0, 0, jdo_addr(24'hFFFFFF, 1'b1));
        n_total++;
        if (avm_read !== 1'b1 || avm_address !== 26'h3FFFFFC)
            $display("FAIL wrap_req: rd %b addr %h want 1 3fffffc", avm_read, avm_address);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (MonDReg !== 32'h00FFFFFF || avm_address !== 26'h0)
            $display("FAIL wrap_done: data %h addr %h want 00ffffff 0", MonDReg, avm_address);
        else n_pass++;
        avm_waitrequest = 1'b1;
        pulse(0, 0, 1, '0);
        n_total++;
        if (avm_read !== 1'b1 || monitor_ready !== 1'b0)
            $display("FAIL pre_reset: rd %b rdy %b want 1 0", avm_read, monitor_ready);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_total++;
        if (avm_read !== 1'b0 || monitor_ready !== 1'b1 || MonDReg !== 32'h0 || avm_address !== 26'h0)
            $display("FAIL async_reset: rd %b rdy %b data %h addr %h want 0 1 0 0",
                     avm_read, monitor_ready, MonDReg, avm_address);
        else n_pass++;
        @(negedge clk);
        avm_waitrequest = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_write_read();
        test_streaming();
        test_wait(5, 26'h90, 32'h24);
        test_wait(7, 26'h94, 32'h25);
        test_timeout();
        test_busy_strobe();
        test_priority();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks done", n_pass, n_total);
        $fatal(1);
    end

endmodule
